sbox5_mont_sequencer: RTL and testbench

- Computes the Poseidon S-box x^5 over the BLS12-381 scalar field with three Montgomery multiplications: x2=x*x, x4=x2*x2, x5=x4*x.
- Acts as the initiator on the multiplier's op/res valid-ready interface. It drives operand requests and consumes results from one external Montgomery multiplier instance.
- Sits between the round-state datapath (upstream) and the MDS stage (downstream).
- All values stay in the Montgomery domain; no domain conversion is done here.

---
 rtl/sbox5_mont_sequencer.sv | 101 ++++++++++
 tb/tb_sbox5_mont_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox5_mont_sequencer.sv
// sbox5_mont_sequencer: Poseidon S-box x^5 over the BLS12-381 scalar field.
// Drives one external Montgomery multiplier through three products:
// x2 = x*x, x4 = x2*x2, x5 = x4*x. Values stay in the Montgomery domain.
// Every output is decoded from the state register, so nothing combinational
// runs from an upstream/downstream valid or ready to an output.
module sbox5_mont_sequencer #(
   parameter int                    DATA_WIDTH = 255,
   parameter logic [DATA_WIDTH-1:0] MODULUS    =
      255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  mul_valid_o,
   input  logic                  mul_ready_i,
   output logic [DATA_WIDTH-1:0] mul_op1_o,
   output logic [DATA_WIDTH-1:0] mul_op2_o,
   input  logic                  mul_res_valid_i,
   output logic                  mul_res_ready_o,
   input  logic [DATA_WIDTH-1:0] mul_res_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  busy_o
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] ISSUE_SQ1 = 3'd1;
   localparam logic [2:0] WAIT_SQ1  = 3'd2;
   localparam logic [2:0] ISSUE_SQ2 = 3'd3;
   localparam logic [2:0] WAIT_SQ2  = 3'd4;
   localparam logic [2:0] ISSUE_MUL = 3'd5;
   localparam logic [2:0] WAIT_MUL  = 3'd6;
   localparam logic [2:0] OUT       = 3'd7;

   logic [2:0]            state;
   logic [DATA_WIDTH-1:0] x_r;    // input element, held until the final product returns
   logic [DATA_WIDTH-1:0] acc_r;  // running power: x^2, then x^4

   logic in_fire, mul_fire, res_fire, out_fire;

   assign in_fire  = in_valid_i && in_ready_o;
   assign mul_fire = mul_valid_o && mul_ready_i;
   assign res_fire = mul_res_valid_i && mul_res_ready_o;
   assign out_fire = out_valid_o && out_ready_i;

   // State sequencing and operand/result capture; reset abandons any element in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         x_r        <= '0;
         acc_r      <= '0;
         out_data_o <= '0;
      end else begin
         case (state)
            IDLE:      if (in_fire) begin
                          x_r   <= in_data_i;
                          state <= ISSUE_SQ1;
                       end
            ISSUE_SQ1: if (mul_fire) state <= WAIT_SQ1;
            WAIT_SQ1:  if (res_fire) begin
                          acc_r <= mul_res_i;
                          state <= ISSUE_SQ2;
                       end
            ISSUE_SQ2: if (mul_fire) state <= WAIT_SQ2;
            WAIT_SQ2:  if (res_fire) begin
                          acc_r <= mul_res_i;
                          state <= ISSUE_MUL;
                       end
            ISSUE_MUL: if (mul_fire) state <= WAIT_MUL;
            WAIT_MUL:  if (res_fire) begin
                          out_data_o <= mul_res_i;
                          state      <= OUT;
                       end
            OUT:       if (out_fire) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   // Handshake outputs and operand mux, decoded purely from state.
   // in_ready_o is also gated by rst so nothing is accepted while reset is held.
   always_comb begin
      in_ready_o      = rst && (state == IDLE);
      mul_valid_o     = (state == ISSUE_SQ1) || (state == ISSUE_SQ2) || (state == ISSUE_MUL);
      mul_res_ready_o = (state == WAIT_SQ1) || (state == WAIT_SQ2) || (state == WAIT_MUL);
      out_valid_o     = (state == OUT);
      busy_o          = (state != IDLE);
      mul_op1_o       = (state == ISSUE_SQ1) ? x_r : acc_r;
      mul_op2_o       = ((state == ISSUE_SQ1) || (state == ISSUE_MUL)) ? x_r : acc_r;
   end

   // Sanity: inputs arrive reduced, and the multiplier never sees an issue and a wait together.
   always_ff @(posedge clk) begin
      if (rst && in_fire) assert (in_data_i < MODULUS);
      if (rst) assert (!(mul_valid_o && mul_res_ready_o));
   end

endmodule

// File: tb/tb_sbox5_mont_sequencer.sv
// Bench for sbox5_mont_sequencer: a modular-multiplier responder, a scoreboard
// of expected operand pairs and x^5 results, and a cycle monitor that checks
// handshake rules, backpressure stability, latency and reset behaviour.
module tb_sbox5_mont_sequencer;

   localparam logic [254:0] P =
      255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

   typedef struct {
      logic [254:0] a;
      logic [254:0] b;
   } op_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid_i, in_ready_o;
   logic [254:0] in_data_i;
   logic         mul_valid_o, mul_ready_i;
   logic [254:0] mul_op1_o, mul_op2_o;
   logic         mul_res_valid_i, mul_res_ready_o;
   logic [254:0] mul_res_i;
   logic         out_valid_o, out_ready_i;
   logic [254:0] out_data_o;
   logic         busy_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int op_cnt = 0;

   logic [254:0] exp_out[$];
   op_t          exp_op[$];

   bit rand_mode = 1'b0;
   int fix_dly   = 1;
   bit mon_en    = 1'b0;
   bit lat_arm   = 1'b0;

   sbox5_mont_sequencer dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
      .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_i),
      .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
      .mul_res_valid_i(mul_res_valid_i), .mul_res_ready_o(mul_res_ready_o),
      .mul_res_i(mul_res_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
      logic [509:0] p, m;
      p = {255'b0, a} * {255'b0, b};
      m = p % {255'b0, P};
      return m[254:0];
   endfunction

   // Multiplier responder: drives at negedge, observes transfers 1 time unit before posedge.
   initial begin
      bit           op_fire, res_fire, stall, pend;
      int           cnt, d;
      logic [254:0] f1, f2, s1, s2, prod;
      op_fire = 0; res_fire = 0; stall = 0; pend = 0; cnt = 0;
      f1 = '0; f2 = '0; s1 = '0; s2 = '0; prod = '0;
      mul_ready_i = 1'b0; mul_res_valid_i = 1'b0; mul_res_i = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            mul_res_valid_i = 1'b0; mul_ready_i = 1'b0;
            pend = 0; op_fire = 0; res_fire = 0; stall = 0;
         end else begin
            if (res_fire) mul_res_valid_i = 1'b0;
            if (stall) begin
               chk("op1_stable", mul_op1_o, s1);
               chk("op2_stable", mul_op2_o, s2);
            end
            if (op_fire) begin
               prod = mulmod(f1, f2);
               d    = rand_mode ? int'($urandom_range(0, 10)) : fix_dly;
               cnt  = (d < 1) ? 1 : d;
               pend = 1;
            end
            if (pend) begin
               if (cnt <= 1) begin
                  mul_res_valid_i = 1'b1; mul_res_i = prod; pend = 0;
               end else cnt--;
            end
            mul_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            op_fire  = rst && mul_valid_o && mul_ready_i;
            res_fire = rst && mul_res_valid_i && mul_res_ready_o;
            stall    = rst && mul_valid_o && !mul_ready_i;
            s1 = mul_op1_o; s2 = mul_op2_o;
            if (op_fire) begin
               op_cnt++;
               f1 = mul_op1_o; f2 = mul_op2_o;
               chk("one_outstanding", {254'b0, pend | mul_res_valid_i}, '0);
               if (exp_op.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL op_unexpected: got (%0h,%0h) expected none", f1, f2);
               end else begin
                  op_t e;
                  e = exp_op.pop_front();
                  chk("mul_op1", f1, e.a);
                  chk("mul_op2", f2, e.b);
               end
            end
         end
      end
   end

   // Cycle monitor and output scoreboard.
   initial begin
      bit           exp_busy, hold, prev_ov, in_f, out_f;
      logic [254:0] hold_data;
      int           acc_cyc;
      exp_busy = 0; hold = 0; prev_ov = 0; hold_data = '0; acc_cyc = 0;
      forever begin
         @(negedge clk);
         #4;
         if (mon_en) begin
            in_f  = rst && in_valid_i && in_ready_o;
            out_f = rst && out_valid_o && out_ready_i;
            chk("in_ready", {254'b0, in_ready_o}, {254'b0, rst && !exp_busy});
            chk("busy", {254'b0, busy_o}, {254'b0, exp_busy});
            if (!exp_busy) chk("idle_outputs", {252'b0, mul_valid_o, mul_res_ready_o, out_valid_o}, '0);
            chk("mul_exclusive", {254'b0, mul_valid_o && mul_res_ready_o}, '0);
            if (rst) chk("res_protocol", {254'b0, mul_res_valid_i && !mul_res_ready_o}, '0);
            if (hold) begin
               chk("bp_out_valid", {254'b0, out_valid_o}, 255'd1);
               chk("bp_out_data", out_data_o, hold_data);
            end
            if (lat_arm && out_valid_o && !prev_ov) begin
               chk("latency", 255'(cyc - acc_cyc), 255'd7);
               lat_arm = 0;
            end
            if (out_f) begin
               if (exp_out.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL out_unexpected: got %0h expected none", out_data_o);
               end else chk("out_data", out_data_o, exp_out.pop_front());
            end
            if (in_f) acc_cyc = cyc;
            hold      = rst && out_valid_o && !out_ready_i;
            hold_data = out_data_o;
            prev_ov   = out_valid_o;
            if (!rst)       exp_busy = 0;
            else if (out_f) exp_busy = 0;
            else if (in_f)  exp_busy = 1;
         end
      end
   end

   task automatic send(input logic [254:0] x, input logic [254:0] x2,
                       input logic [254:0] x4, input logic [254:0] x5);
      int n;
      exp_op.push_back('{a: x,  b: x});
      exp_op.push_back('{a: x2, b: x2});
      exp_op.push_back('{a: x4, b: x});
      exp_out.push_back(x5);
      in_valid_i = 1'b1;
      in_data_i  = x;
      n = 0;
      while (!in_ready_o && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready_o) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 for x=%0h", x);
      end
      @(negedge clk);
      in_valid_i = 1'b0;
      in_data_i  = 255'hdead;  // post-accept changes must not matter
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_out.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (exp_out.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_out.size());
      end
   endtask

   initial begin
      int           base, n;
      logic [255:0] w;
      logic [254:0] x, x2, x4;
      rst = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      chk("reset_out_data", out_data_o, '0);
      chk("reset_in_ready_held", {254'b0, in_ready_o}, '0);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", {254'b0, in_ready_o}, 255'd1);

      // x=2, delay 1: ops (2,2),(4,4),(16,2), result 32, latency 7
      lat_arm = 1'b1;
      send(255'd2, 255'd4, 255'd16, 255'd32);
      drain();

      // back-to-back 3 then 0
      send(255'd3, 255'd9, 255'd81, 255'd243);
      send(255'd0, 255'd0, 255'd0, 255'd0);
      drain();

      // (-1)^5 = -1
      send(P - 255'd1, 255'd1, 255'd1, P - 255'd1);
      drain();

      // downstream backpressure for 20 cycles in OUT
      out_ready_i = 1'b0;
      send(255'd5, 255'd25, 255'd625, 255'd3125);
      n = 0;
      while (!out_valid_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("bp_reached_out", {254'b0, out_valid_o}, 255'd1);
      repeat (20) begin
         @(negedge clk);
         chk("bp_in_ready_low", {254'b0, in_ready_o}, '0);
      end
      out_ready_i = 1'b1;
      drain();
      @(negedge clk);
      chk("bp_back_idle", {254'b0, busy_o}, '0);

      // reset while waiting on the second square
      fix_dly = 6;
      base = op_cnt;
      send(255'd7, 255'd49, 255'd2401, 255'd16807);
      n = 0;
      while (op_cnt < base + 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reached_wait_sq2", 255'(op_cnt - base), 255'd2);
      rst = 1'b0;
      exp_op.delete();
      exp_out.delete();
      @(negedge clk);
      chk("rst_outputs", {251'b0, mul_valid_o, mul_res_ready_o, out_valid_o, in_ready_o}, '0);
      chk("rst_busy", {254'b0, busy_o}, '0);
      @(negedge clk);
      rst = 1'b1;
      fix_dly = 1;
      @(negedge clk);
      send(255'd2, 255'd4, 255'd16, 255'd32);
      drain();

      // random multiplier readiness and latency, 1000 random elements
      rand_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom();
         x  = w[254:0] % P;
         x2 = mulmod(x, x);
         x4 = mulmod(x2, x2);
         send(x, x2, x4, mulmod(x4, x));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
